// File: rtl/uart16550_rxfifo_ctrl_if.sv
// Receive buffer bus between the serial receiver / register file
// and the 16550 receive FIFO controller.
interface uart16550_rxfifo_ctrl_if #(
   parameter int DEPTH = 16
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic          baudout_i;
   logic          push_i;
   logic [7:0]    d_i;
   logic          pe_i;
   logic          fe_i;
   logic          bi_i;
   logic          fifo_en_i;
   logic          rx_clr_i;
   logic [1:0]    trig_sel_i;
   logic [7:0]    char_time_i;
   logic          pop_i;
   logic          lsr_rd_i;
   logic [7:0]    q_o;
   logic          q_pe_o;
   logic          q_fe_o;
   logic          q_bi_o;
   logic          dr_o;
   logic          oe_o;
   logic          err_o;
   logic [LW-1:0] level_o;
   logic          trig_o;
   logic          timeout_o;

   modport master (
      output baudout_i, push_i, d_i, pe_i, fe_i, bi_i,
      output fifo_en_i, rx_clr_i, trig_sel_i, char_time_i,
      output pop_i, lsr_rd_i,
      input  q_o, q_pe_o, q_fe_o, q_bi_o, dr_o, oe_o,
      input  err_o, level_o, trig_o, timeout_o
   );

   modport slave (
      input  baudout_i, push_i, d_i, pe_i, fe_i, bi_i,
      input  fifo_en_i, rx_clr_i, trig_sel_i, char_time_i,
      input  pop_i, lsr_rd_i,
      output q_o, q_pe_o, q_fe_o, q_bi_o, dr_o, oe_o,
      output err_o, level_o, trig_o, timeout_o
   );
endinterface

// File: rtl/uart16550_rxfifo_ctrl.sv
// 16550 receive buffer: FIFO/16450 storage, LSR status bits,
// trigger-level and character-timeout interrupt requests.
module uart16550_rxfifo_ctrl #(
   parameter int DEPTH   = 16,
   parameter int TO_MULT = 4
) (
   input logic                    clk_i,
   input logic                    rst_i,
   uart16550_rxfifo_ctrl_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [10:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0] lvl_q, lvl_d, err_q, err_d;
   logic [9:0]    to_q, to_d, lim;
   logic          oe_q, oe_d, fen_q;
   logic          clr, empty, full;
   logic          push_ok, pop_ok, ovr, flg_in;
   logic [10:0]   head;
   int            thr;

   // a mode switch flushes the buffer exactly like an FCR[1] write
   assign clr     = bus.rx_clr_i | (bus.fifo_en_i ^ fen_q);
   assign empty   = (lvl_q == '0);
   assign full    = bus.fifo_en_i ? (lvl_q == LW'(DEPTH)) : !empty;
   assign pop_ok  = bus.pop_i & !empty;
   assign push_ok = bus.push_i & (!full | pop_ok);
   assign ovr     = bus.push_i & full & !pop_ok & !clr;
   assign flg_in  = bus.pe_i | bus.fe_i | bus.bi_i;
   assign head    = empty ? '0 : mem_q[rd_q];
   assign lim     = 10'(TO_MULT * int'(bus.char_time_i));

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      lvl_d = lvl_q;
      err_d = err_q;
      to_d  = to_q;
      oe_d  = ovr | (oe_q & !bus.lsr_rd_i);
      if (clr) begin
         rd_d  = '0;
         wr_d  = '0;
         lvl_d = '0;
         err_d = '0;
         to_d  = '0;
      end else begin
         if (push_ok) wr_d = wr_q + PW'(1);
         if (pop_ok)  rd_d = rd_q + PW'(1);
         lvl_d = lvl_q + LW'(push_ok) - LW'(pop_ok);
         err_d = err_q + LW'(push_ok & flg_in)
               - LW'(pop_ok & (|head[10:8]));
         if (bus.push_i | bus.pop_i | empty | !bus.fifo_en_i)
            to_d = '0;
         else if (bus.baudout_i && to_q < lim)
            to_d = to_q + 10'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         lvl_q <= '0;
         err_q <= '0;
         to_q  <= '0;
         oe_q  <= 1'b0;
         fen_q <= bus.fifo_en_i;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         lvl_q <= lvl_d;
         err_q <= err_d;
         to_q  <= to_d;
         oe_q  <= oe_d;
         fen_q <= bus.fifo_en_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !clr && push_ok)
         mem_q[wr_q] <= {bus.bi_i, bus.fe_i, bus.pe_i, bus.d_i};
   end

   always_comb begin
      case (bus.trig_sel_i)
         2'b00:   thr = 1;
         2'b01:   thr = 4;
         2'b10:   thr = 8;
         default: thr = 14;
      endcase
      if (!bus.fifo_en_i) thr = 1;
   end

   assign bus.q_o       = head[7:0];
   assign bus.q_pe_o    = head[8];
   assign bus.q_fe_o    = head[9];
   assign bus.q_bi_o    = head[10];
   assign bus.dr_o      = !empty;
   assign bus.oe_o      = oe_q;
   assign bus.err_o     = (err_q != '0);
   assign bus.level_o   = lvl_q;
   assign bus.trig_o    = (int'(lvl_q) >= thr);
   assign bus.timeout_o = bus.fifo_en_i & !empty & (to_q >= lim);
endmodule
